resize_frame_driver: RTL

- Sequencer that drives one complete frame through the resize filter and captures the result.
- Reads source pixels from a synchronous-read frame memory and streams them into the filter under the load strobe. Then asserts the process strobe for the resized pixel count and writes each filter output to a destination memory.
- Sits between the source/destination frame buffers and the resize filter; the top-level start/done handshake runs one resize per request.

---
 rtl/resize_frame_driver_if.sv | 31 +++
 rtl/resize_frame_driver.sv | 121 ++++++++++++
 2 files changed

// File: rtl/resize_frame_driver_if.sv
// Handshake and memory/filter bus between the resize frame sequencer and its surroundings.
// The master side is the sequencer; the slave side is the frame buffers, filter and requester.
interface resize_frame_driver_if;
  logic        start;
  logic        size;
  logic [31:0] src_addr;
  logic [7:0]  src_data;
  logic        filt_rst;
  logic        filt_load;
  logic        filt_proc;
  logic        filt_size;
  logic [7:0]  filt_pix;
  logic [7:0]  filt_data;
  logic        dst_we;
  logic [31:0] dst_addr;
  logic [7:0]  dst_data;
  logic        busy;
  logic        done;

  modport master (
    input  start, size, src_data, filt_data,
    output src_addr, filt_rst, filt_load, filt_proc, filt_size, filt_pix,
           dst_we, dst_addr, dst_data, busy, done
  );

  modport slave (
    output start, size, src_data, filt_data,
    input  src_addr, filt_rst, filt_load, filt_proc, filt_size, filt_pix,
           dst_we, dst_addr, dst_data, busy, done
  );
endinterface

// File: rtl/resize_frame_driver.sv
// Runs one source frame through the resize filter and writes the filter results to the destination buffer.
// states: IDLE wait start | CLEAR filt_rst | PREFETCH pixel 0 read | LOAD stream pixels | PROCESS capture | DRAIN last write | DONE pulse
module resize_frame_driver #(
  parameter int unsigned DEPTH = 410,
  parameter int unsigned WIDTH = 361
) (
  input logic                   clk,
  input logic                   rst,
  resize_frame_driver_if.master bus
);
  localparam logic [31:0] FRAME    = 32'(DEPTH * WIDTH);
  localparam logic [31:0] OUT_UP   = 32'((2 * DEPTH) * (2 * WIDTH));
  localparam logic [31:0] OUT_DOWN = 32'((DEPTH / 2) * (WIDTH / 2));

  typedef enum logic [2:0] {IDLE, CLEAR, PREFETCH, LOAD, PROCESS, DRAIN, DONE} state_t;

  state_t      state_q;
  logic [31:0] cnt_q;
  logic [31:0] src_addr_q;
  logic [31:0] dst_addr_q;
  logic        size_q;
  logic        filt_rst_q;
  logic        filt_load_q;
  logic        filt_proc_q;
  logic        dst_we_q;
  logic        busy_q;
  logic        done_q;
  logic [31:0] n_out;

  assign n_out = size_q ? OUT_UP : OUT_DOWN;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      src_addr_q  <= '0;
      dst_addr_q  <= '0;
      size_q      <= 1'b0;
      filt_rst_q  <= 1'b0;
      filt_load_q <= 1'b0;
      filt_proc_q <= 1'b0;
      dst_we_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q    <= CLEAR;
            size_q     <= bus.size;
            busy_q     <= 1'b1;
            filt_rst_q <= 1'b1;
            src_addr_q <= '0;
            cnt_q      <= '0;
          end
        end
        CLEAR: begin
          state_q    <= PREFETCH;
          filt_rst_q <= 1'b0;
        end
        PREFETCH: begin
          state_q     <= LOAD;
          filt_load_q <= 1'b1;
          src_addr_q  <= 32'd1;
        end
        LOAD: begin
          if (cnt_q == FRAME - 32'd1) begin
            filt_load_q <= 1'b0;
            cnt_q       <= '0;
            // a degenerate down-size has nothing to process
            if (n_out == 32'd0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q     <= PROCESS;
              filt_proc_q <= 1'b1;
            end
          end else begin
            cnt_q      <= cnt_q + 32'd1;
            src_addr_q <= cnt_q + 32'd2;
          end
        end
        PROCESS: begin
          // filter output lags the process strobe by one cycle, so write step j-1 during step j
          dst_we_q   <= 1'b1;
          dst_addr_q <= cnt_q;
          if (cnt_q == n_out - 32'd1) begin
            filt_proc_q <= 1'b0;
            state_q     <= DRAIN;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        DRAIN: begin
          dst_we_q <= 1'b0;
          state_q  <= DONE;
          done_q   <= 1'b1;
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // pixel and result buses pass straight through: memory and filter latency already align them with the strobes
  assign bus.filt_pix  = filt_load_q ? bus.src_data : 8'd0;
  assign bus.dst_data  = dst_we_q ? bus.filt_data : 8'd0;
  assign bus.src_addr  = src_addr_q;
  assign bus.dst_addr  = dst_addr_q;
  assign bus.filt_rst  = filt_rst_q;
  assign bus.filt_load = filt_load_q;
  assign bus.filt_proc = filt_proc_q;
  assign bus.filt_size = size_q;
  assign bus.dst_we    = dst_we_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
endmodule
